// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/data request ports and the shared memory bus
//   i_*   : fetch port (read-only) request, address, read data, done, stall
//   d_*   : data port request, write flag, address, write data, read data, done, stall
//   err   : unaligned-access pulse, coincides with the completing port's done
//   mem_* : single-ported fixed-latency memory strobes, address, data
//   slave : arbiter view, master : pipeline/memory view
interface mem_port_arbiter_if;
    logic        i_req;
    logic [15:0] i_addr;
    logic [15:0] i_rdata;
    logic        i_done;
    logic        i_stall;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_done;
    logic        d_stall;
    logic        err;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        output i_rdata, i_done, i_stall, d_rdata, d_done, d_stall, err,
               mem_en, mem_wr, mem_addr, mem_wdata
    );
    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        input  i_rdata, i_done, i_stall, d_rdata, d_done, d_stall, err,
               mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between fetch and data ports
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : mem_port_arbiter_if.slave (port handshakes, err, memory bus)
// Data wins ties unless the fetch port has already watched STARVE_LIMIT
// consecutive data grants. One transaction is in flight at a time.
module mem_port_arbiter #(
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 3
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] ERRC = 2'd2;
    localparam logic [3:0] LAST_CNT   = 4'(LATENCY - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [1:0]  state;
    logic        gntD;
    logic        latWr;
    logic [15:0] latAddr;
    logic [15:0] latWdata;
    logic [3:0]  cnt;
    logic [3:0]  starve;
    logic        pickD;
    logic        pickI;
    logic        busyStart;
    logic        finish;
    logic [15:0] nextAddr;
    logic [15:0] readBack;

    always_comb begin
        pickD     = bus.d_req && !(bus.i_req && starve == STARVE_MAX);
        pickI     = bus.i_req && !pickD;
        nextAddr  = pickD ? bus.d_addr : bus.i_addr;
        busyStart = state == BUSY && cnt == 4'd0;
        finish    = (state == BUSY && cnt == LAST_CNT) || state == ERRC;
        // writes and error completions return zero data
        readBack  = (state == BUSY && !latWr) ? bus.mem_rdata : 16'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gntD     <= 1'b0;
            latWr    <= 1'b0;
            latAddr  <= 16'd0;
            latWdata <= 16'd0;
            cnt      <= 4'd0;
            starve   <= 4'd0;
        end else begin
            case (state)
                IDLE: if (pickD || pickI) begin
                    state    <= nextAddr[0] ? ERRC : BUSY;
                    gntD     <= pickD;
                    latWr    <= pickD && bus.d_wr;
                    latAddr  <= nextAddr;
                    latWdata <= pickD ? bus.d_wdata : 16'd0;
                    cnt      <= 4'd0;
                    // a data grant over a waiting fetch only happens below
                    // STARVE_MAX, so the increment cannot overshoot
                    starve   <= (pickD && bus.i_req) ? starve + 4'd1 : 4'd0;
                end
                BUSY: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_CNT)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.i_done    = finish && !gntD;
    assign bus.d_done    = finish && gntD;
    assign bus.err       = state == ERRC;
    assign bus.i_rdata   = bus.i_done ? readBack : 16'd0;
    assign bus.d_rdata   = bus.d_done ? readBack : 16'd0;
    assign bus.i_stall   = bus.i_req && !bus.i_done;
    assign bus.d_stall   = bus.d_req && !bus.d_done;
    assign bus.mem_en    = busyStart;
    assign bus.mem_wr    = busyStart && latWr;
    assign bus.mem_addr  = latAddr;
    assign bus.mem_wdata = latWdata;
endmodule
